// File: rtl/noc_ni_param.sv
// noc_ni_param: NoC network interface between a processor port and a router port.
// TX splits one word plus destination into header, data flits and a tail flit.
// RX rebuilds inbound packets into words and queues them in an RX_DEPTH FIFO.
// Build option: define NI_ZERO_SUPPRESS_EN to drop trailing all-zero data flits on TX.
// The RX path is the same in both builds and zero-fills any flits that were not sent.
//
// TX FSM
//   state   | meaning
//   TX_IDLE | ready for a processor word (proc_ready=1)
//   TX_HEAD | driving header flit {HDR_TAG, dest}
//   TX_DATA | driving data flit tx_idx, LSB flit first
//   TX_TAIL | driving TAIL_FLIT with noc_tx_last=1
// RX FSM
//   state   | meaning
//   RX_HEAD | expecting a header flit
//   RX_DATA | collecting data flits until the last-marked tail
//   RX_DROP | discarding a malformed packet through its last flit
`timescale 1ns/1ps
module noc_ni_param #(
  parameter int                       FLIT_W    = 8,
  parameter int                       DATA_W    = 32,
  parameter int                       ADDR_W    = 2,
  parameter logic [FLIT_W-ADDR_W-1:0] HDR_TAG   = 6'b101111,
  parameter logic [FLIT_W-1:0]        TAIL_FLIT = {FLIT_W{1'b1}},
  parameter int                       RX_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              proc_valid,
  output logic              proc_ready,
  input  logic [ADDR_W-1:0] proc_dest,
  input  logic [DATA_W-1:0] proc_data,
  output logic [FLIT_W-1:0] noc_tx_flit,
  output logic              noc_tx_valid,
  output logic              noc_tx_last,
  input  logic              noc_tx_ready,
  input  logic [FLIT_W-1:0] noc_rx_flit,
  input  logic              noc_rx_valid,
  input  logic              noc_rx_last,
  output logic              noc_rx_ready,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [ADDR_W-1:0] rx_dest,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_err
);

  localparam int N       = DATA_W / FLIT_W;
  localparam int CNT_W   = $clog2(N + 1);
  localparam int TAG_W   = FLIT_W - ADDR_W;
  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int PTR_W   = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int OCC_W   = $clog2(RX_DEPTH + 1);

  // ---------------------------------------------------------------- TX path
  typedef enum logic [1:0] {TX_IDLE, TX_HEAD, TX_DATA, TX_TAIL} tx_state_t;

  tx_state_t         tx_state, tx_state_d;
  logic [ADDR_W-1:0] tx_dest;
  logic [DATA_W-1:0] tx_data;
  logic [CNT_W-1:0]  tx_nflit;
  logic [CNT_W-1:0]  tx_idx;
  logic [CNT_W-1:0]  nflit_calc;
  logic [FLIT_W-1:0] tx_data_flit;
  logic              tx_accept;

  assign proc_ready = (tx_state == TX_IDLE);
  assign tx_accept  = proc_valid && proc_ready;

  // Number of data flits to send for the word being offered
  always_comb begin
    nflit_calc = CNT_W'(N);
`ifdef NI_ZERO_SUPPRESS_EN
    nflit_calc = CNT_W'(1);
    for (int i = 1; i < N; i++) begin
      if (proc_data[i*FLIT_W +: FLIT_W] != '0) nflit_calc = CNT_W'(i + 1);
    end
`endif
  end

  // Select the data flit addressed by tx_idx
  always_comb begin
    tx_data_flit = tx_data[FLIT_W-1:0];
    for (int i = 1; i < N; i++) begin
      if (tx_idx == CNT_W'(i)) tx_data_flit = tx_data[i*FLIT_W +: FLIT_W];
    end
  end

  // TX state register and latched word; reset abandons any packet in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_dest  <= '0;
      tx_data  <= '0;
      tx_nflit <= '0;
      tx_idx   <= '0;
    end else begin
      tx_state <= tx_state_d;
      if (tx_accept) begin
        tx_dest  <= proc_dest;
        tx_data  <= proc_data;
        tx_nflit <= nflit_calc;
      end
      if (tx_state == TX_HEAD) begin
        tx_idx <= '0;
      end else if (tx_state == TX_DATA && noc_tx_ready) begin
        tx_idx <= tx_idx + CNT_W'(1);
      end
    end
  end

  // TX next state and flit outputs; outputs hold while the router stalls
  always_comb begin
    tx_state_d   = tx_state;
    noc_tx_valid = 1'b0;
    noc_tx_last  = 1'b0;
    noc_tx_flit  = '0;
    case (tx_state)
      TX_IDLE: begin
        if (tx_accept) tx_state_d = TX_HEAD;
      end
      TX_HEAD: begin
        noc_tx_valid = 1'b1;
        noc_tx_flit  = {HDR_TAG, tx_dest};
        if (noc_tx_ready) tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        noc_tx_valid = 1'b1;
        noc_tx_flit  = tx_data_flit;
        if (noc_tx_ready && tx_idx == tx_nflit - CNT_W'(1)) tx_state_d = TX_TAIL;
      end
      TX_TAIL: begin
        noc_tx_valid = 1'b1;
        noc_tx_last  = 1'b1;
        noc_tx_flit  = TAIL_FLIT;
        if (noc_tx_ready) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX path
  typedef enum logic [1:0] {RX_HEAD, RX_DATA, RX_DROP} rx_state_t;

  rx_state_t         rx_state, rx_state_d;
  logic [ADDR_W-1:0] rx_hdr_dest;
  logic [DATA_W-1:0] rx_asm;
  logic [CNT_W-1:0]  rx_cnt;
  logic [TAG_W-1:0]  rx_tag;
  logic              rx_take;
  logic              rx_hdr_ok;
  logic              rx_store;
  logic              rx_push;
  logic              rx_pop;
  logic              rx_err_d;
  logic              fifo_full;
  logic              fifo_empty;

  assign noc_rx_ready = !fifo_full;
  assign rx_take      = noc_rx_valid && noc_rx_ready;
  assign rx_tag       = noc_rx_flit[FLIT_W-1:ADDR_W];

  // RX packet parser: decides store / push / error for the flit being taken
  always_comb begin
    rx_state_d = rx_state;
    rx_hdr_ok  = 1'b0;
    rx_store   = 1'b0;
    rx_push    = 1'b0;
    rx_err_d   = 1'b0;
    if (rx_take) begin
      case (rx_state)
        RX_HEAD: begin
          if (rx_tag != HDR_TAG) begin
            rx_err_d   = 1'b1;
            rx_state_d = noc_rx_last ? RX_HEAD : RX_DROP;
          end else if (noc_rx_last) begin
            rx_err_d = 1'b1;
          end else begin
            rx_hdr_ok  = 1'b1;
            rx_state_d = RX_DATA;
          end
        end
        RX_DATA: begin
          if (!noc_rx_last) begin
            if (rx_cnt < CNT_W'(N)) begin
              rx_store = 1'b1;
            end else begin
              rx_err_d   = 1'b1;
              rx_state_d = RX_DROP;
            end
          end else begin
            rx_state_d = RX_HEAD;
            if (noc_rx_flit == TAIL_FLIT && rx_cnt != '0) rx_push  = 1'b1;
            else                                          rx_err_d = 1'b1;
          end
        end
        RX_DROP: begin
          if (noc_rx_last) rx_state_d = RX_HEAD;
        end
        default: rx_state_d = RX_HEAD;
      endcase
    end
  end

  // RX state, header capture and word assembly; assembly is cleared per packet
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state    <= RX_HEAD;
      rx_hdr_dest <= '0;
      rx_asm      <= '0;
      rx_cnt      <= '0;
      rx_err      <= 1'b0;
    end else begin
      rx_state <= rx_state_d;
      rx_err   <= rx_err_d;
      if (rx_hdr_ok) begin
        rx_hdr_dest <= noc_rx_flit[ADDR_W-1:0];
        rx_asm      <= '0;
        rx_cnt      <= '0;
      end else if (rx_store) begin
        for (int i = 0; i < N; i++) begin
          if (rx_cnt == CNT_W'(i)) rx_asm[i*FLIT_W +: FLIT_W] <= noc_rx_flit;
        end
        rx_cnt <= rx_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [ENTRY_W-1:0] fifo_mem [RX_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   fifo_cnt;

  assign fifo_full  = (fifo_cnt == OCC_W'(RX_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign rx_valid   = !fifo_empty;
  assign rx_pop     = rx_ready && !fifo_empty;
  assign {rx_dest, rx_data} = fifo_mem[rd_ptr];

  // FIFO storage; contents need no reset since rx_valid gates them
  always_ff @(posedge clk) begin
    if (rst_n && rx_push) fifo_mem[wr_ptr] <= {rx_hdr_dest, rx_asm};
  end

  // FIFO pointers and occupancy; push never sees full because noc_rx_ready gates it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (rx_push) wr_ptr <= (wr_ptr == PTR_W'(RX_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (rx_pop)  rd_ptr <= (rd_ptr == PTR_W'(RX_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({rx_push, rx_pop})
        2'b10:   fifo_cnt <= fifo_cnt + OCC_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - OCC_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_ni_param.sv
// tb_noc_ni_param: scoreboard bench for noc_ni_param (TX flits, RX words, rx_err pulses).
`timescale 1ns/1ps
module tb_noc_ni_param;

  localparam logic [5:0] TAG  = 6'b101111;
  localparam logic [7:0] TAIL = 8'hFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        proc_valid = 1'b0;
  logic        proc_ready;
  logic [1:0]  proc_dest = '0;
  logic [31:0] proc_data = '0;
  logic [7:0]  noc_tx_flit;
  logic        noc_tx_valid;
  logic        noc_tx_last;
  logic        noc_tx_ready;
  logic [7:0]  noc_rx_flit;
  logic        noc_rx_valid;
  logic        noc_rx_last;
  logic        noc_rx_ready;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [1:0]  rx_dest;
  logic [31:0] rx_data;
  logic        rx_err;

  logic        lb = 1'b0;
  logic        tb_tx_ready = 1'b0;
  logic [7:0]  tb_rx_flit = '0;
  logic        tb_rx_valid = 1'b0;
  logic        tb_rx_last = 1'b0;

  always #5 clk = ~clk;

  assign noc_rx_flit  = lb ? noc_tx_flit  : tb_rx_flit;
  assign noc_rx_valid = lb ? noc_tx_valid : tb_rx_valid;
  assign noc_rx_last  = lb ? noc_tx_last  : tb_rx_last;
  assign noc_tx_ready = lb ? noc_rx_ready : tb_tx_ready;

  noc_ni_param #(
    .FLIT_W(8), .DATA_W(32), .ADDR_W(2),
    .HDR_TAG(6'b101111), .TAIL_FLIT(8'hFF), .RX_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .proc_valid(proc_valid), .proc_ready(proc_ready),
    .proc_dest(proc_dest), .proc_data(proc_data),
    .noc_tx_flit(noc_tx_flit), .noc_tx_valid(noc_tx_valid),
    .noc_tx_last(noc_tx_last), .noc_tx_ready(noc_tx_ready),
    .noc_rx_flit(noc_rx_flit), .noc_rx_valid(noc_rx_valid),
    .noc_rx_last(noc_rx_last), .noc_rx_ready(noc_rx_ready),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_dest(rx_dest), .rx_data(rx_data), .rx_err(rx_err)
  );

  logic [8:0]  txq[$];
  logic [33:0] rxq[$];
  int          checks = 0;
  int          errors = 0;
  int          err_seen = 0;
  bit          proc_acc = 1'b0;
  bit          rx_take = 1'b0;
  bit          rand_rx = 1'b0;
  bit          held_valid = 1'b0;
  logic [7:0]  held_flit = '0;
  logic        held_last = 1'b0;

  function automatic int exp_nflit(input logic [31:0] d);
    int n;
    n = 4;
`ifdef NI_ZERO_SUPPRESS_EN
    n = 1;
    for (int i = 1; i < 4; i++) if (d[i*8 +: 8] != 8'h00) n = i + 1;
`endif
    return n;
  endfunction

  // One clock: sample at negedge (scoreboard pops, stall stability, err pulses), return at posedge+1
  task automatic cycle();
    logic [8:0]  etx;
    logic [33:0] erx;
    @(negedge clk);
    proc_acc = proc_valid && proc_ready && rst_n;
    rx_take  = noc_rx_valid && noc_rx_ready && rst_n;
    if (held_valid) begin
      checks++;
      if (noc_tx_valid !== 1'b1 || noc_tx_flit !== held_flit || noc_tx_last !== held_last) begin
        errors++;
        $display("FAIL tx_stable: got valid=%0b flit=%h last=%0b, required valid=1 flit=%h last=%0b",
                 noc_tx_valid, noc_tx_flit, noc_tx_last, held_flit, held_last);
      end
    end
    held_valid = noc_tx_valid && !noc_tx_ready && rst_n;
    held_flit  = noc_tx_flit;
    held_last  = noc_tx_last;
    if (noc_tx_valid && noc_tx_ready && rst_n) begin
      checks++;
      if (txq.size() == 0) begin
        errors++;
        $display("FAIL tx_extra: got flit=%h last=%0b, required no flit", noc_tx_flit, noc_tx_last);
      end else begin
        etx = txq.pop_front();
        if ({noc_tx_last, noc_tx_flit} !== etx) begin
          errors++;
          $display("FAIL tx_flit: got last=%0b flit=%h, required last=%0b flit=%h",
                   noc_tx_last, noc_tx_flit, etx[8], etx[7:0]);
        end
      end
    end
    if (rx_valid && rx_ready && rst_n) begin
      checks++;
      if (rxq.size() == 0) begin
        errors++;
        $display("FAIL rx_extra: got dest=%0d data=%h, required no word", rx_dest, rx_data);
      end else begin
        erx = rxq.pop_front();
        if ({rx_dest, rx_data} !== erx) begin
          errors++;
          $display("FAIL rx_word: got dest=%0d data=%h, required dest=%0d data=%h",
                   rx_dest, rx_data, erx[33:32], erx[31:0]);
        end
      end
    end
    if (rx_err === 1'b1) err_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx_exp(input logic [1:0] dest, input logic [31:0] data);
    int n;
    n = exp_nflit(data);
    txq.push_back({1'b0, TAG, dest});
    for (int i = 0; i < n; i++) txq.push_back({1'b0, data[i*8 +: 8]});
    txq.push_back({1'b1, TAIL});
  endtask

  task automatic send_word(input logic [1:0] dest, input logic [31:0] data, input bit expect_rx);
    int n;
    push_tx_exp(dest, data);
    if (expect_rx) rxq.push_back({dest, data});
    proc_valid = 1'b1;
    proc_dest  = dest;
    proc_data  = data;
    n = 0;
    do begin
      cycle();
      n++;
      if (rand_rx) rx_ready = 1'($urandom_range(0, 1));
    end while (!proc_acc && n < 100);
    proc_valid = 1'b0;
    if (!proc_acc) begin
      checks++;
      errors++;
      $display("FAIL proc_accept_timeout: got no accept in %0d cycles, required accept", n);
    end
  endtask

  task automatic send_flit(input logic [7:0] f, input logic l);
    int n;
    tb_rx_valid = 1'b1;
    tb_rx_flit  = f;
    tb_rx_last  = l;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!rx_take && n < 50);
    tb_rx_valid = 1'b0;
    if (!rx_take) begin
      checks++;
      errors++;
      $display("FAIL rx_send_timeout: flit %h not taken in %0d cycles, required taken", f, n);
    end
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((txq.size() != 0 || rxq.size() != 0) && n < bound) begin
      cycle();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    checks += 6;
    if (proc_ready !== 1'b1)   begin errors++; $display("FAIL rst_proc_ready: got %b, required 1", proc_ready); end
    if (noc_tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b, required 0", noc_tx_valid); end
    if (noc_tx_last !== 1'b0)  begin errors++; $display("FAIL rst_tx_last: got %b, required 0", noc_tx_last); end
    if (noc_rx_ready !== 1'b1) begin errors++; $display("FAIL rst_rx_ready: got %b, required 1", noc_rx_ready); end
    if (rx_valid !== 1'b0)     begin errors++; $display("FAIL rst_rx_valid: got %b, required 0", rx_valid); end
    if (rx_err !== 1'b0)       begin errors++; $display("FAIL rst_rx_err: got %b, required 0", rx_err); end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_loopback_word();
    int e0;
    e0 = err_seen;
    lb = 1'b1;
    rx_ready = 1'b1;
    send_word(2'd2, 32'h0000_00A5, 1'b1);
    checks++;
    if (noc_tx_valid !== 1'b1 || noc_tx_flit !== 8'hBE) begin
      errors++;
      $display("FAIL hdr_latency: got valid=%b flit=%h, required valid=1 flit=be", noc_tx_valid, noc_tx_flit);
    end
    drain(40);
    checks += 3;
    if (txq.size() != 0 || rxq.size() != 0) begin
      errors++;
      $display("FAIL loopback_drain: got tx_left=%0d rx_left=%0d, required 0 and 0", txq.size(), rxq.size());
    end
    if (err_seen != e0) begin errors++; $display("FAIL loopback_err: got %0d pulses, required 0", err_seen - e0); end
    if (proc_ready !== 1'b1 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL loopback_idle: got proc_ready=%b rx_valid=%b, required 1 and 0", proc_ready, rx_valid);
    end
  endtask

  task automatic test_tx_stall();
    int i;
    lb = 1'b0;
    tb_tx_ready = 1'b0;
    send_word(2'd0, 32'hDEAD_BEEF, 1'b0);
    i = 0;
    while (txq.size() != 0 && i < 40) begin
      tb_tx_ready = (i % 2 == 1);
      cycle();
      i++;
    end
    tb_tx_ready = 1'b0;
    cycle();
    checks += 2;
    if (txq.size() != 0) begin errors++; $display("FAIL stall_drain: got %0d flits left, required 0", txq.size()); end
    if (noc_tx_valid !== 1'b0 || proc_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_idle: got tx_valid=%b proc_ready=%b, required 0 and 1", noc_tx_valid, proc_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [8];
    int e0;
    e0 = err_seen;
    w[0] = 32'h0000_0000;
    w[1] = 32'hFF00_0000;
    w[2] = 32'h0001_0000;
    w[3] = 32'h0000_0080;
    for (int i = 4; i < 8; i++) w[i] = $urandom;
    lb = 1'b1;
    rand_rx = 1'b1;
    for (int i = 0; i < 8; i++) send_word(2'(i), w[i], 1'b1);
    rand_rx = 1'b0;
    rx_ready = 1'b1;
    drain(200);
    checks += 2;
    if (txq.size() != 0 || rxq.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got tx_left=%0d rx_left=%0d, required 0 and 0", txq.size(), rxq.size());
    end
    if (err_seen != e0) begin errors++; $display("FAIL b2b_err: got %0d pulses, required 0", err_seen - e0); end
  endtask

  task automatic test_fifo_full();
    bit took;
    lb = 1'b0;
    rx_ready = 1'b0;
    rxq.push_back({2'd1, 32'h4433_2211});
    send_flit(8'hBD, 1'b0);
    send_flit(8'h11, 1'b0);
    send_flit(8'h22, 1'b0);
    send_flit(8'h33, 1'b0);
    send_flit(8'h44, 1'b0);
    send_flit(TAIL, 1'b1);
    rxq.push_back({2'd3, 32'h0000_3344});
    send_flit(8'hBF, 1'b0);
    send_flit(8'h44, 1'b0);
    send_flit(8'h33, 1'b0);
    send_flit(TAIL, 1'b1);
    checks++;
    if (noc_rx_ready !== 1'b0 || rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL fifo_full: got rx_ready_out=%b rx_valid=%b, required 0 and 1", noc_rx_ready, rx_valid);
    end
    rxq.push_back({2'd0, 32'h0000_0077});
    tb_rx_valid = 1'b1;
    tb_rx_flit  = 8'hBC;
    tb_rx_last  = 1'b0;
    took = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      took |= rx_take;
    end
    checks++;
    if (took) begin errors++; $display("FAIL fifo_block: got header taken while full, required held off"); end
    rx_ready = 1'b1;
    cycle();
    rx_ready = 1'b0;
    send_flit(8'hBC, 1'b0);
    send_flit(8'h77, 1'b0);
    send_flit(TAIL, 1'b1);
    checks++;
    if (noc_rx_ready !== 1'b0) begin errors++; $display("FAIL fifo_refill: got rx_ready_out=%b, required 0", noc_rx_ready); end
    rx_ready = 1'b1;
    drain(20);
    cycle();
    checks++;
    if (rxq.size() != 0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL fifo_drain: got rx_left=%0d rx_valid=%b, required 0 and 0", rxq.size(), rx_valid);
    end
  endtask

  task automatic test_rx_malformed();
    int e0;
    e0 = err_seen;
    lb = 1'b0;
    rx_ready = 1'b1;
    send_flit(8'h7C, 1'b0); send_flit(8'h11, 1'b0); send_flit(TAIL, 1'b1);
    send_flit(8'hBD, 1'b1);
    send_flit(8'hBD, 1'b0); send_flit(TAIL, 1'b1);
    send_flit(8'hBD, 1'b0); send_flit(8'h12, 1'b0); send_flit(8'h00, 1'b1);
    send_flit(8'h7C, 1'b1);
    cycle();
    cycle();
    checks += 2;
    if (err_seen - e0 != 5) begin errors++; $display("FAIL bad_pkt_err: got %0d pulses, required 5", err_seen - e0); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL bad_pkt_push: got rx_valid=%b, required 0", rx_valid); end
    rxq.push_back({2'd1, 32'h0000_005A});
    send_flit(8'hBD, 1'b0); send_flit(8'h5A, 1'b0); send_flit(TAIL, 1'b1);
    drain(20);
    cycle();
    checks += 2;
    if (rxq.size() != 0) begin errors++; $display("FAIL recover_word: got %0d words left, required 0", rxq.size()); end
    if (err_seen - e0 != 5) begin errors++; $display("FAIL recover_err: got %0d pulses, required 5", err_seen - e0); end
  endtask

  task automatic test_rx_overflow();
    int e0;
    e0 = err_seen;
    lb = 1'b0;
    rx_ready = 1'b1;
    send_flit(8'hBC, 1'b0);
    for (int i = 1; i <= 6; i++) send_flit(8'(i), 1'b0);
    send_flit(TAIL, 1'b1);
    cycle();
    cycle();
    checks += 2;
    if (err_seen - e0 != 1) begin errors++; $display("FAIL ovf_err: got %0d pulses, required 1", err_seen - e0); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_push: got rx_valid=%b, required 0", rx_valid); end
    rxq.push_back({2'd2, 32'h0000_0099});
    send_flit(8'hBE, 1'b0); send_flit(8'h99, 1'b0); send_flit(TAIL, 1'b1);
    drain(20);
    checks++;
    if (rxq.size() != 0 || err_seen - e0 != 1) begin
      errors++;
      $display("FAIL ovf_recover: got rx_left=%0d pulses=%0d, required 0 and 1", rxq.size(), err_seen - e0);
    end
  endtask

  task automatic test_reset_mid_tx();
    lb = 1'b0;
    tb_tx_ready = 1'b0;
    send_word(2'd1, 32'h1234_5678, 1'b0);
    tb_tx_ready = 1'b1;
    cycle();
    cycle();
    tb_tx_ready = 1'b0;
    rst_n = 1'b0;
    cycle();
    checks++;
    if (proc_ready !== 1'b1 || noc_tx_valid !== 1'b0 || noc_tx_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got proc_ready=%b tx_valid=%b tx_last=%b, required 1 0 0",
               proc_ready, noc_tx_valid, noc_tx_last);
    end
    rst_n = 1'b1;
    txq.delete();
    tb_tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    checks++;
    if (noc_tx_valid !== 1'b0) begin errors++; $display("FAIL no_tail: got tx_valid=%b after reset, required 0", noc_tx_valid); end
  endtask

  initial begin
    test_reset();
    test_loopback_word();
    test_tx_stall();
    test_back_to_back();
    test_fifo_full();
    test_rx_malformed();
    test_rx_overflow();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
